// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared constants and write-back control types for the pipeline
//          registers of the 5-stage 32-bit RISC core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // Bubble value for the write-back controls; no register write, ALU path selected.
  localparam wb_ctrl_t WB_CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/pipe_reg.sv
// ============================================================================
// Module : pipe_reg
// Brief  : Generic W-bit pipeline register, async active-low reset to zero.
//          With PIPE_MEM_WB_STALL_FLUSH_EN defined, adds en_i (hold when low)
//          and clr_i (load zero, wins over en_i).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
  input  logic         en_i,
  input  logic         clr_i,
`endif
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = d_i;
`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
    if (clr_i) begin
      q_d = '0;
    end else if (!en_i) begin
      q_d = q_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/pipe_mem_wb.sv
// ============================================================================
// Module : pipe_mem_wb
// Brief  : MEM/WB pipeline register; captures memory-stage results and
//          write-back controls every rising edge, async active-low reset.
//          Option PIPE_MEM_WB_STALL_FLUSH_EN adds STALL_IN / FLUSH_IN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_mem_wb
  import pipe_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
  input  logic              STALL_IN,
  input  logic              FLUSH_IN,
`endif
  input  logic              MEMTOREG_IN,
  input  logic              REGWRITE_IN,
  input  logic [WIDTH-1:0]  MEMDATA_IN,
  input  logic [WIDTH-1:0]  RESULTOP_IN,
  input  logic [ADDR_W-1:0] ARD_IN,
  output logic              MEMTOREG_OUT,
  output logic              REGWRITE_OUT,
  output logic [WIDTH-1:0]  MEMDATA_OUT,
  output logic [WIDTH-1:0]  RESULTOP_OUT,
  output logic [ADDR_W-1:0] ARD_OUT
);

  localparam int CTRL_W = $bits(wb_ctrl_t);

  wb_ctrl_t ctrl_d;
  wb_ctrl_t ctrl_q;

  assign ctrl_d.memtoreg = MEMTOREG_IN;
  assign ctrl_d.regwrite = REGWRITE_IN;

`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
  // A flush must zero every field, so all instances share the same en/clr.
  logic en;
  logic clr;
  assign en  = ~STALL_IN;
  assign clr = FLUSH_IN;
`define PIPE_MEM_WB_CTL .en_i(en), .clr_i(clr),
`else
`define PIPE_MEM_WB_CTL
`endif

  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst), `PIPE_MEM_WB_CTL
    .d_i(ctrl_d), .q_o(ctrl_q)
  );

  pipe_reg #(.W(WIDTH)) u_memdata (
    .clk(clk), .rst_n(rst), `PIPE_MEM_WB_CTL
    .d_i(MEMDATA_IN), .q_o(MEMDATA_OUT)
  );

  pipe_reg #(.W(WIDTH)) u_resultop (
    .clk(clk), .rst_n(rst), `PIPE_MEM_WB_CTL
    .d_i(RESULTOP_IN), .q_o(RESULTOP_OUT)
  );

  pipe_reg #(.W(ADDR_W)) u_ard (
    .clk(clk), .rst_n(rst), `PIPE_MEM_WB_CTL
    .d_i(ARD_IN), .q_o(ARD_OUT)
  );

`undef PIPE_MEM_WB_CTL

  assign MEMTOREG_OUT = ctrl_q.memtoreg;
  assign REGWRITE_OUT = ctrl_q.regwrite;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_wb.sv
// ============================================================================
// Module : tb_pipe_mem_wb
// Brief  : Scoreboard bench for pipe_mem_wb; expectations are queued by the
//          stimulus thread and popped by an independent monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_mem_wb;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [31:0] md;
    logic [31:0] res;
    logic [4:0]  ard;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m2r_i = 1'b0, rw_i = 1'b0;
  logic [31:0] md_i = '0, res_i = '0;
  logic [4:0]  ard_i = '0;
  logic        m2r_o, rw_o;
  logic [31:0] md_o, res_o;
  logic [4:0]  ard_o;
`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
  logic        stall_i = 1'b0, flush_i = 1'b0;
`endif

  obs_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  event  chk_now;

  always #5 clk = ~clk;

  pipe_mem_wb dut (
    .clk(clk), .rst(rst),
`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
    .STALL_IN(stall_i), .FLUSH_IN(flush_i),
`endif
    .MEMTOREG_IN(m2r_i), .REGWRITE_IN(rw_i), .MEMDATA_IN(md_i),
    .RESULTOP_IN(res_i), .ARD_IN(ard_i),
    .MEMTOREG_OUT(m2r_o), .REGWRITE_OUT(rw_o), .MEMDATA_OUT(md_o),
    .RESULTOP_OUT(res_o), .ARD_OUT(ard_o)
  );

  localparam obs_t ZERO = '0;

  // Monitor: one pop per rising edge or per explicit mid-cycle sample request.
  initial begin
    obs_t  got, e;
    string nm;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = '{m2r_o, rw_o, md_o, res_o, ard_o};
        n_chk++;
        if (got === e) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got m2r=%b rw=%b md=%h res=%h ard=%b, expected m2r=%b rw=%b md=%h res=%h ard=%b",
                   nm, got.m2r, got.rw, got.md, got.res, got.ard,
                   e.m2r, e.rw, e.md, e.res, e.ard);
        end
      end
    end
  end

  task automatic drive(input obs_t v);
    m2r_i = v.m2r; rw_i = v.rw; md_i = v.md; res_i = v.res; ard_i = v.ard;
  endtask

  task automatic expect_edge(input string nm, input obs_t v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic expect_now(input string nm, input obs_t v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    -> chk_now;
  endtask

  initial begin
    obs_t v1, v2, v3, tbl[3];
    v1 = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'b10101};
    v2 = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h87654321, 5'b01110};
    v3 = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h13579BDF, 5'b11111};
    tbl[0] = '{1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 5'b00000};
    tbl[1] = '{1'b1, 1'b0, 32'h5A5A5A5A, 32'h00000001, 5'b00001};
    tbl[2] = '{1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 5'b10000};

    // Asynchronous reset with busy inputs, sampled before any clock edge
    #1;
    drive(v1);
    rst = 1'b0;
    #1;
    expect_now("rst_async", ZERO);
    @(negedge clk);
    expect_edge("rst_hold_edge", ZERO);

    @(negedge clk);
    rst = 1'b1;
    drive(v1);
    expect_edge("capture", v1);

    @(negedge clk);
    drive(v2);
    expect_now("hold_prev", v1);
    expect_edge("update", v2);

    // Reset dropped between edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_now("rst_mid", ZERO);
    @(negedge clk);
    drive(v1);
    expect_edge("rst_mid_edge", ZERO);

    @(negedge clk);
    rst = 1'b1;
    drive(v3);
    expect_now("release_hold", ZERO);
    expect_edge("release_cap", v3);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      expect_edge($sformatf("table_%0d", i), tbl[i]);
    end

`ifdef PIPE_MEM_WB_STALL_FLUSH_EN
    @(negedge clk);
    drive(v1);
    expect_edge("opt_load", v1);
    @(negedge clk);
    stall_i = 1'b1;
    drive(v2);
    expect_edge("opt_stall", v1);
    @(negedge clk);
    stall_i = 1'b0;
    flush_i = 1'b1;
    expect_edge("opt_flush", ZERO);
    @(negedge clk);
    flush_i = 1'b0;
    drive(v3);
    expect_edge("opt_reload", v3);
    @(negedge clk);
    stall_i = 1'b1;
    flush_i = 1'b1;
    drive(v1);
    expect_edge("opt_flush_over_stall", ZERO);
    @(negedge clk);
    stall_i = 1'b0;
    flush_i = 1'b0;
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
